// File: rtl/text_console.sv
// Character-stream writer driving the textbuffer CPU port: prints at the cursor,
// handles CR/LF/BS/FF and scrolls the screen up by copying cells through the port.
module text_console #(
  parameter  int WIDTH  = 20,
  parameter  int HEIGHT = 15,
  localparam int AW     = $clog2(WIDTH*HEIGHT)+1,
  localparam int CW     = $clog2(WIDTH),
  localparam int RW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    char_in,
  input  logic [7:0]    attr_in,
  input  logic          char_valid,
  output logic          char_ready,
  output logic          busy,
  output logic [CW-1:0] cur_col,
  output logic [RW-1:0] cur_row,
  output logic          tb_cs,
  output logic          tb_rw,
  output logic [AW-1:0] tb_addr,
  output logic [7:0]    tb_di,
  input  logic [7:0]    tb_dout
);

  localparam int PW    = AW-1;
  localparam int NCELL = WIDTH*HEIGHT;
  localparam int NCOPY = WIDTH*(HEIGHT-1);

  typedef enum logic [3:0] {
    S_IDLE, S_PUT_C, S_PUT_A,
    S_RD_C, S_WT_C, S_WR_C, S_RD_A, S_WT_A, S_WR_A,
    S_CLRROW_C, S_CLRROW_A, S_CLR_C, S_CLR_A
  } state_t;

  state_t        r_state, w_state_n;
  logic [PW-1:0] r_idx, w_idx_n;
  logic [CW-1:0] r_col, w_col_n;
  logic [RW-1:0] r_row, w_row_n;
  logic          r_cs, w_cs_n, r_rw, w_rw_n;
  logic [AW-1:0] r_addr, w_addr_n;
  logic [7:0]    r_di, w_di_n, r_attr;

  logic [PW-1:0] w_p, w_idx1, w_src_next, w_src_cur;
  logic          w_last_row, w_last_col;

  assign w_p        = PW'(r_row) * PW'(WIDTH) + PW'(r_col);
  assign w_idx1     = r_idx + 1'b1;
  assign w_src_cur  = r_idx + PW'(WIDTH);
  assign w_src_next = r_idx + PW'(WIDTH+1);
  assign w_last_row = (r_row == RW'(HEIGHT-1));
  assign w_last_col = (r_col == CW'(WIDTH-1));

  // Bus outputs are registered: each branch loads the access belonging to the state being entered.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_col_n   = r_col;
    w_row_n   = r_row;
    w_cs_n    = 1'b0;
    w_rw_n    = 1'b0;
    w_addr_n  = '0;
    w_di_n    = '0;
    case (r_state)
      S_IDLE: if (char_valid) begin
        case (char_in)
          8'h0D: w_col_n = '0;
          8'h08: if (r_col != '0) w_col_n = r_col - 1'b1;
          8'h0A: begin
            w_col_n = '0;
            if (w_last_row) begin
              w_state_n = S_RD_C; w_idx_n = '0;
              w_cs_n = 1'b1; w_addr_n = {1'b0, PW'(WIDTH)};
            end else w_row_n = r_row + 1'b1;
          end
          8'h0C: begin
            w_state_n = S_CLR_C; w_idx_n = '0;
            w_cs_n = 1'b1; w_rw_n = 1'b1; w_addr_n = '0; w_di_n = 8'h20;
          end
          default: begin
            w_state_n = S_PUT_C;
            w_cs_n = 1'b1; w_rw_n = 1'b1; w_addr_n = {1'b0, w_p}; w_di_n = char_in;
          end
        endcase
      end
      S_PUT_C: begin
        w_state_n = S_PUT_A;
        w_cs_n = 1'b1; w_rw_n = 1'b1; w_addr_n = {1'b1, w_p}; w_di_n = r_attr;
      end
      S_PUT_A: begin
        w_state_n = S_IDLE;
        if (w_last_col) begin
          w_col_n = '0;
          if (w_last_row) begin
            w_state_n = S_RD_C; w_idx_n = '0;
            w_cs_n = 1'b1; w_addr_n = {1'b0, PW'(WIDTH)};
          end else w_row_n = r_row + 1'b1;
        end else w_col_n = r_col + 1'b1;
      end
      S_RD_C: w_state_n = S_WT_C;
      S_WT_C: begin
        w_state_n = S_WR_C;
        w_cs_n = 1'b1; w_rw_n = 1'b1; w_addr_n = {1'b0, r_idx}; w_di_n = tb_dout;
      end
      S_WR_C: begin
        w_state_n = S_RD_A;
        w_cs_n = 1'b1; w_addr_n = {1'b1, w_src_cur};
      end
      S_RD_A: w_state_n = S_WT_A;
      S_WT_A: begin
        w_state_n = S_WR_A;
        w_cs_n = 1'b1; w_rw_n = 1'b1; w_addr_n = {1'b1, r_idx}; w_di_n = tb_dout;
      end
      S_WR_A: begin
        w_idx_n = w_idx1;
        w_cs_n  = 1'b1;
        if (r_idx == PW'(NCOPY-1)) begin
          w_state_n = S_CLRROW_C;
          w_rw_n = 1'b1; w_addr_n = {1'b0, w_idx1}; w_di_n = 8'h20;
        end else begin
          w_state_n = S_RD_C;
          w_addr_n = {1'b0, w_src_next};
        end
      end
      S_CLRROW_C, S_CLR_C: begin
        w_state_n = (r_state == S_CLR_C) ? S_CLR_A : S_CLRROW_A;
        w_cs_n = 1'b1; w_rw_n = 1'b1; w_addr_n = {1'b1, r_idx}; w_di_n = r_attr;
      end
      S_CLRROW_A, S_CLR_A: begin
        if (r_idx == PW'(NCELL-1)) begin
          w_state_n = S_IDLE;
          if (r_state == S_CLR_A) begin
            w_col_n = '0;
            w_row_n = '0;
          end
        end else begin
          w_state_n = (r_state == S_CLR_A) ? S_CLR_C : S_CLRROW_C;
          w_idx_n = w_idx1;
          w_cs_n = 1'b1; w_rw_n = 1'b1; w_addr_n = {1'b0, w_idx1}; w_di_n = 8'h20;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_cs    <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_di    <= '0;
      r_attr  <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_col   <= w_col_n;
      r_row   <= w_row_n;
      r_cs    <= w_cs_n;
      r_rw    <= w_rw_n;
      r_addr  <= w_addr_n;
      r_di    <= w_di_n;
      if (r_state == S_IDLE && char_valid) r_attr <= attr_in;
    end
  end

  assign char_ready = (r_state == S_IDLE);
  assign busy       = ~char_ready;
  assign cur_col    = r_col;
  assign cur_row    = r_row;
  assign tb_cs      = r_cs;
  assign tb_rw      = r_rw;
  assign tb_addr    = r_addr;
  assign tb_di      = r_di;

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: acts as the textbuffer, scoreboards every write, checks cursor and timing.
module tb_text_console;
  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] char_in = '0, attr_in = '0;
  logic       char_valid = 1'b0;
  logic       char_ready, busy, tb_cs, tb_rw;
  logic [4:0] cur_col;
  logic [3:0] cur_row;
  logic [9:0] tb_addr;
  logic [7:0] tb_di;
  logic [7:0] tb_dout = '0;

  text_console #(.WIDTH(20), .HEIGHT(15)) dut (
    .clk(clk), .reset(reset), .char_in(char_in), .attr_in(attr_in), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy), .cur_col(cur_col), .cur_row(cur_row),
    .tb_cs(tb_cs), .tb_rw(tb_rw), .tb_addr(tb_addr), .tb_di(tb_di), .tb_dout(tb_dout)
  );

  always #5 clk = ~clk;

  // textbuffer: synchronous read, data visible the cycle after the read
  logic [7:0] mem [0:1023];
  always @(posedge clk) if (tb_cs === 1'b1) begin
    if (tb_rw) mem[tb_addr] <= tb_di;
    else       tb_dout <= mem[tb_addr];
  end

  int total = 0, bad = 0, acc_cnt = 0;
  int ecol = 0, erow = 0;
  bit sb_on = 1'b1;
  logic [17:0] sb[$];
  logic [7:0]  shadow [0:1023];

  function automatic void push_wr(input logic [9:0] a, input logic [7:0] d);
    sb.push_back({a, d});
    shadow[a] = d;
  endfunction

  function automatic void push_scroll(input logic [7:0] a);
    for (int i = 0; i < 280; i++) begin
      push_wr(10'(i), shadow[i+20]);
      push_wr(10'(512+i), shadow[512+i+20]);
    end
    for (int i = 280; i < 300; i++) begin
      push_wr(10'(i), 8'h20);
      push_wr(10'(512+i), a);
    end
  endfunction

  task automatic monitor();
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (tb_cs === 1'b1) begin
        acc_cnt++;
        if (tb_rw === 1'b1 && sb_on) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: write addr=%0d data=%h, none expected", tb_addr, tb_di);
          end else begin
            e = sb.pop_front();
            if ({tb_addr, tb_di} !== e) begin
              bad++;
              $display("FAIL sb_write: got addr=%0d data=%h want addr=%0d data=%h",
                       tb_addr, tb_di, e[17:8], e[7:0]);
            end
          end
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    @(negedge clk);
    char_in = c; attr_in = a; char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in = 8'($urandom);
    attr_in = 8'($urandom);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (char_ready !== 1'b1 && cyc < 4000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic type_char(input logic [7:0] c, input logic [7:0] a, output int cyc);
    case (c)
      8'h0D: ecol = 0;
      8'h08: if (ecol > 0) ecol--;
      8'h0A: begin ecol = 0; if (erow == 14) push_scroll(a); else erow++; end
      8'h0C: begin
        for (int i = 0; i < 300; i++) begin push_wr(10'(i), 8'h20); push_wr(10'(512+i), a); end
        ecol = 0; erow = 0;
      end
      default: begin
        push_wr(10'(erow*20+ecol), c);
        push_wr(10'(512+erow*20+ecol), a);
        if (ecol == 19) begin ecol = 0; if (erow == 14) push_scroll(a); else erow++; end
        else ecol++;
      end
    endcase
    send(c, a);
    wait_ready(cyc);
  endtask

  task automatic test_reset();
    reset = 1'b1; char_valid = 1'b1; char_in = 8'h5A;
    repeat (3) @(negedge clk);
    reset = 1'b0; char_valid = 1'b0;
    @(negedge clk);
    total++; if (char_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", char_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if ({tb_cs, tb_rw} !== 2'b00) begin bad++; $display("FAIL rst_cs_rw: got %b want 00", {tb_cs, tb_rw}); end
    total++; if (tb_addr !== 10'd0 || tb_di !== 8'd0) begin bad++; $display("FAIL rst_bus: got addr=%0d di=%h want 0/00", tb_addr, tb_di); end
    total++; if (cur_col !== 5'd0 || cur_row !== 4'd0) begin bad++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
    total++; if (acc_cnt !== 0) begin bad++; $display("FAIL rst_access: got %0d want 0", acc_cnt); end
  endtask

  task automatic test_single_char();
    int cyc;
    type_char(8'h41, 8'h1F, cyc);
    total++; if (cyc !== 2) begin bad++; $display("FAIL single_busy: got %0d want 2", cyc); end
    total++; if (cur_col !== 5'd1 || cur_row !== 4'd0) begin bad++; $display("FAIL single_cursor: got (%0d,%0d) want (1,0)", cur_col, cur_row); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL single_pending: got %0d want 0", sb.size()); end
    total++; if (mem[0] !== 8'h41 || mem[512] !== 8'h1F) begin bad++; $display("FAIL single_mem: got %h/%h want 41/1f", mem[0], mem[512]); end
  endtask

  task automatic test_full_row();
    int cyc;
    type_char(8'h0D, 8'h00, cyc);
    for (int k = 0; k < 20; k++) type_char(8'(8'h61 + k), 8'(k), cyc);
    total++; if (cyc !== 2) begin bad++; $display("FAIL row_last_busy: got %0d want 2", cyc); end
    total++; if (cur_col !== 5'd0 || cur_row !== 4'd1) begin bad++; $display("FAIL row_cursor: got (%0d,%0d) want (0,1)", cur_col, cur_row); end
    total++; if (mem[19] !== 8'h74 || mem[531] !== 8'h13) begin bad++; $display("FAIL row_last_mem: got %h/%h want 74/13", mem[19], mem[531]); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL row_pending: got %0d want 0", sb.size()); end
  endtask

  task automatic test_controls();
    int cyc, a0;
    type_char(8'h0A, 8'h00, cyc);
    type_char(8'h0A, 8'h00, cyc);
    for (int k = 0; k < 5; k++) type_char(8'h2A, 8'h0E, cyc);
    total++; if (cur_col !== 5'd5 || cur_row !== 4'd3) begin bad++; $display("FAIL ctl_start: got (%0d,%0d) want (5,3)", cur_col, cur_row); end
    a0 = acc_cnt;
    type_char(8'h08, 8'h00, cyc);
    total++; if (cur_col !== 5'd4 || cur_row !== 4'd3) begin bad++; $display("FAIL ctl_bs_mid: got (%0d,%0d) want (4,3)", cur_col, cur_row); end
    type_char(8'h0D, 8'h00, cyc);
    total++; if (cur_col !== 5'd0 || cur_row !== 4'd3) begin bad++; $display("FAIL ctl_cr: got (%0d,%0d) want (0,3)", cur_col, cur_row); end
    total++; if (cyc !== 0) begin bad++; $display("FAIL ctl_cr_busy: got %0d want 0", cyc); end
    type_char(8'h08, 8'h00, cyc);
    total++; if (cur_col !== 5'd0 || cur_row !== 4'd3) begin bad++; $display("FAIL ctl_bs0: got (%0d,%0d) want (0,3)", cur_col, cur_row); end
    type_char(8'h0A, 8'h00, cyc);
    total++; if (cur_col !== 5'd0 || cur_row !== 4'd4) begin bad++; $display("FAIL ctl_lf: got (%0d,%0d) want (0,4)", cur_col, cur_row); end
    type_char(8'h08, 8'h00, cyc);
    total++; if (cur_col !== 5'd0 || cur_row !== 4'd4) begin bad++; $display("FAIL ctl_bs1: got (%0d,%0d) want (0,4)", cur_col, cur_row); end
    total++; if (acc_cnt !== a0) begin bad++; $display("FAIL ctl_accesses: got %0d want 0", acc_cnt - a0); end
  endtask

  task automatic test_clear();
    int cyc;
    type_char(8'h0C, 8'h2E, cyc);
    total++; if (cyc !== 600) begin bad++; $display("FAIL clr_busy: got %0d want 600", cyc); end
    total++; if (cur_col !== 5'd0 || cur_row !== 4'd0) begin bad++; $display("FAIL clr_cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL clr_pending: got %0d want 0", sb.size()); end
    total++; if (mem[299] !== 8'h20 || mem[811] !== 8'h2E) begin bad++; $display("FAIL clr_last: got %h/%h want 20/2e", mem[299], mem[811]); end
  endtask

  task automatic test_scroll_lf();
    int cyc;
    type_char(8'h0A, 8'h00, cyc);
    for (int k = 0; k < 20; k++) type_char(8'h58, 8'h07, cyc);
    for (int k = 0; k < 12; k++) type_char(8'h0A, 8'h00, cyc);
    total++; if (cur_row !== 4'd14) begin bad++; $display("FAIL scr_pre_row: got %0d want 14", cur_row); end
    type_char(8'h0A, 8'h5A, cyc);
    total++; if (cyc !== 1720) begin bad++; $display("FAIL scr_busy: got %0d want 1720", cyc); end
    total++; if (cur_col !== 5'd0 || cur_row !== 4'd14) begin bad++; $display("FAIL scr_cursor: got (%0d,%0d) want (0,14)", cur_col, cur_row); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL scr_pending: got %0d want 0", sb.size()); end
    for (int i = 0; i < 20; i++) begin
      total++; if (mem[i] !== 8'h58 || mem[512+i] !== 8'h07) begin bad++; $display("FAIL scr_row0[%0d]: got %h/%h want 58/07", i, mem[i], mem[512+i]); end
      total++; if (mem[280+i] !== 8'h20 || mem[792+i] !== 8'h5A) begin bad++; $display("FAIL scr_row14[%0d]: got %h/%h want 20/5a", i, mem[280+i], mem[792+i]); end
    end
  endtask

  task automatic test_scroll_wrap();
    int cyc;
    for (int k = 0; k < 19; k++) type_char(8'(8'h30 + k % 10), 8'h4C, cyc);
    total++; if (cur_col !== 5'd19 || cur_row !== 4'd14) begin bad++; $display("FAIL wrap_pre: got (%0d,%0d) want (19,14)", cur_col, cur_row); end
    type_char(8'h5A, 8'h3B, cyc);
    total++; if (cyc !== 1722) begin bad++; $display("FAIL wrap_busy: got %0d want 1722", cyc); end
    total++; if (cur_col !== 5'd0 || cur_row !== 4'd14) begin bad++; $display("FAIL wrap_cursor: got (%0d,%0d) want (0,14)", cur_col, cur_row); end
    total++; if (mem[279] !== 8'h5A || mem[791] !== 8'h3B) begin bad++; $display("FAIL wrap_moved: got %h/%h want 5a/3b", mem[279], mem[791]); end
    total++; if (mem[299] !== 8'h20 || mem[811] !== 8'h3B) begin bad++; $display("FAIL wrap_blank: got %h/%h want 20/3b", mem[299], mem[811]); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL wrap_pending: got %0d want 0", sb.size()); end
  endtask

  task automatic test_reset_mid_scroll();
    int cyc;
    sb_on = 1'b0;
    send(8'h0A, 8'h11);
    repeat (50) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_in_scroll: got busy=%b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (tb_cs !== 1'b0) begin bad++; $display("FAIL abort_cs: got %b want 0", tb_cs); end
    total++; if (cur_col !== 5'd0 || cur_row !== 4'd0) begin bad++; $display("FAIL abort_cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (char_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", char_ready); end
    sb.delete();
    sb_on = 1'b1;
    ecol = 0; erow = 0;
    type_char(8'h42, 8'h66, cyc);
    total++; if (cyc !== 2) begin bad++; $display("FAIL abort_b_busy: got %0d want 2", cyc); end
    total++; if (mem[0] !== 8'h42 || mem[512] !== 8'h66) begin bad++; $display("FAIL abort_b_mem: got %h/%h want 42/66", mem[0], mem[512]); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL abort_pending: got %0d want 0", sb.size()); end
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_single_char();
    test_full_row();
    test_controls();
    test_clear();
    test_scroll_lf();
    test_scroll_wrap();
    test_reset_mid_scroll();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
